car_cmd_arbiter: RTL and testbench

- Sequential successor to the keyboard-to-car command decoder.
- Takes the 512-bit PS/2 key_down vector and drives steering and drive commands to the motor/PWM stage.
- Per-key hold filtering rejects glitches.
- Opposing keys on one axis resolve last-pressed-wins instead of cancelling.
- Drive speed ramps up and down, and a reversal is forced through braking to zero first.

---
 rtl/car_cmd_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_car_cmd_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/car_cmd_arbiter.sv
// car_cmd_arbiter: hold-filtered keyboard keys -> steering/drive commands with speed ramp and braking.
// Optional stuck-key timeout is compiled in when CAR_KEY_TIMEOUT_EN is defined.

module car_key_filter #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (raw != filt) begin
            if (cnt == CW'(HOLD_CYCLES - 1)) begin
                filt <= raw;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end
endmodule

module car_cmd_arbiter #(
    parameter logic [7:0] KEY_LEFT       = 8'h1C,
    parameter logic [7:0] KEY_RIGHT      = 8'h23,
    parameter logic [7:0] KEY_FWD        = 8'h1D,
    parameter logic [7:0] KEY_BACK       = 8'h1B,
    parameter int         HOLD_CYCLES    = 4,
    parameter int         RAMP_CYCLES    = 8,
    parameter int         SPEED_W        = 3,
    parameter int         MAX_LEVEL      = 7,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [511:0]       key_down,
    output logic [1:0]         direc,
    output logic [1:0]         drive,
    output logic [SPEED_W-1:0] speed,
    output logic               braking,
    output logic               cmd_chg
);
    typedef enum logic [1:0] {IDLE, FWD, REV, BRAKE} state_t;

    localparam logic [1:0] SEL_A    = 2'b10;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam int         RW       = $clog2(RAMP_CYCLES + 1);

    // bit order: 0 left, 1 right, 2 forward, 3 back
    logic [3:0] raw, filt, filt_d, rise;
    logic [1:0] last_lr, last_fb, lr_sel, fb_sel, req;
    logic       unused_keys;

    state_t             state, state_n;
    logic [SPEED_W-1:0] speed_n;
    logic [RW-1:0]      ramp_cnt;
    logic               tick;
    logic [1:0]         brake_dir, brake_dir_n;
    logic [SPEED_W+3:0] out_q;

    assign raw = {key_down[{1'b0, KEY_BACK}], key_down[{1'b0, KEY_FWD}],
                  key_down[{1'b0, KEY_RIGHT}], key_down[{1'b0, KEY_LEFT}]};
    assign unused_keys = ^key_down;

    car_key_filter #(.HOLD_CYCLES(HOLD_CYCLES)) u_flt [3:0] (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw),
        .filt  (filt)
    );

    assign rise = filt & ~filt_d;

    // Both held: the later rise wins; simultaneous rises resolve to none.
    function automatic logic [1:0] arb(input logic a, input logic b, input logic ra,
                                       input logic rb, input logic [1:0] last);
        if (a && b) begin
            if (ra && rb) return SEL_NONE;
            if (ra)       return SEL_A;
            if (rb)       return SEL_B;
            return last;
        end
        return {a, b};
    endfunction

    assign lr_sel = arb(filt[0], filt[1], rise[0], rise[1], last_lr);
    assign fb_sel = arb(filt[2], filt[3], rise[2], rise[3], last_fb);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_d  <= '0;
            last_lr <= SEL_NONE;
            last_fb <= SEL_NONE;
            direc   <= SEL_NONE;
        end else begin
            filt_d <= filt;
            direc  <= lr_sel;
            if (rise[0] || rise[1]) last_lr <= lr_sel;
            if (rise[2] || rise[3]) last_fb <= fb_sel;
        end
    end

`ifdef CAR_KEY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;
    logic          to_mask;

    // Mask holds the drive request off until every F/B key is seen released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt  <= '0;
            to_mask <= 1'b0;
        end else begin
            if (filt != filt_d)                    to_cnt <= '0;
            else if (to_cnt != TW'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + 1'b1;
            if (filt[3:2] == 2'b00)
                to_mask <= 1'b0;
            else if (to_cnt == TW'(TIMEOUT_CYCLES) && (state == FWD || state == REV))
                to_mask <= 1'b1;
        end
    end

    assign req = to_mask ? SEL_NONE : fb_sel;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;

    assign req = fb_sel;
`endif

    assign tick = (ramp_cnt == RW'(RAMP_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            speed     <= '0;
            ramp_cnt  <= '0;
            brake_dir <= SEL_NONE;
        end else begin
            state     <= state_n;
            speed     <= speed_n;
            brake_dir <= brake_dir_n;
            ramp_cnt  <= (state_n != state || tick) ? '0 : ramp_cnt + 1'b1;
        end
    end

    always_comb begin
        state_n     = state;
        speed_n     = speed;
        brake_dir_n = brake_dir;
        case (state)
            IDLE: begin
                speed_n = '0;
                if (req == SEL_A)      state_n = FWD;
                else if (req == SEL_B) state_n = REV;
            end
            FWD, REV: begin
                if (req == ((state == FWD) ? SEL_A : SEL_B)) begin
                    if (tick && speed < SPEED_W'(MAX_LEVEL)) speed_n = speed + 1'b1;
                end else begin
                    state_n     = BRAKE;
                    brake_dir_n = (state == FWD) ? SEL_A : SEL_B;
                end
            end
            BRAKE: begin
                // Only the original direction may resume; anything else decays to IDLE first.
                if (speed == '0)            state_n = IDLE;
                else if (req == brake_dir)  state_n = (brake_dir == SEL_A) ? FWD : REV;
                else if (tick)              speed_n = speed - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        drive = SEL_NONE;
        case (state)
            FWD:     drive = SEL_A;
            REV:     drive = SEL_B;
            BRAKE:   drive = brake_dir;
            default: drive = SEL_NONE;
        endcase
    end

    assign braking = (state == BRAKE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= '0;
            cmd_chg <= 1'b0;
        end else begin
            out_q   <= {direc, drive, speed};
            cmd_chg <= ({direc, drive, speed} != out_q);
        end
    end
endmodule

// File: tb/tb_car_cmd_arbiter.sv
// Directed bench for car_cmd_arbiter: every cmd_chg pulse pops one expected output snapshot.
module tb_car_cmd_arbiter;
    localparam int KL = 'h1C, KR = 'h23, KF = 'h1D, KB = 'h1B;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [511:0] key_down = '0;
    logic [1:0]   direc, drive;
    logic [2:0]   speed;
    logic         braking, cmd_chg;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_out = '0;
    logic       mon_en = 1'b0;

    car_cmd_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_down (key_down),
        .direc    (direc),
        .drive    (drive),
        .speed    (speed),
        .braking  (braking),
        .cmd_chg  (cmd_chg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [1:0] d, input logic [1:0] dr, input int s, input logic b);
        exp_q.push_back({d, dr, 3'(s), b});
    endtask

    task automatic drain(input string tag, input int max);
        for (int i = 0; i < max && exp_q.size() != 0; i++) step(1);
        step(2);
        chk(tag, exp_q.size(), 0);
    endtask

    // cmd_chg lags the change by one cycle, so compare the previous sample.
    always @(negedge clk) begin
        if (mon_en && cmd_chg) begin
            if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size() != 0), 1);
            else                   chk("sb_event", last_out, exp_q.pop_front());
        end
        last_out = {direc, drive, speed, braking};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running want done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(3);
        chk("rst_direc", direc, 0);
        chk("rst_drive", drive, 0);
        chk("rst_speed", speed, 0);
        chk("rst_braking", braking, 0);
        chk("rst_cmd_chg", cmd_chg, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        step(1);

        // glitch of 3 cycles is rejected
        key_down[KL] = 1'b1; step(3);
        key_down[KL] = 1'b0; step(8);
        chk("glitch_direc", direc, 0);

        // 4-cycle hold: direc one cycle after the filter flips
        push(2'b10, 2'b00, 0, 0);
        key_down[KL] = 1'b1; step(4);
        chk("hold_pre", direc, 2'b00);
        step(1);
        chk("hold_post", direc, 2'b10);
        step(5);

        // last-pressed-wins on the steering axis
        push(2'b01, 2'b00, 0, 0);
        key_down[KR] = 1'b1; step(4);
        chk("lpw_pre", direc, 2'b10);
        step(1);
        chk("lpw_right", direc, 2'b01);
        step(5);
        push(2'b10, 2'b00, 0, 0);
        key_down[KR] = 1'b0; step(6);
        chk("lpw_back_left", direc, 2'b10);
        push(2'b00, 2'b00, 0, 0);
        key_down[KL] = 1'b0; step(6);
        chk("lpw_none", direc, 2'b00);
        key_down[KL] = 1'b1; key_down[KR] = 1'b1; step(8);
        chk("both_same_edge", direc, 2'b00);
        key_down[KL] = 1'b0; key_down[KR] = 1'b0;
        drain("drain_steer", 20);

        // forward ramp with saturation
        push(2'b00, 2'b10, 0, 0);
        for (int s = 1; s <= 7; s++) push(2'b00, 2'b10, s, 0);
        key_down[KF] = 1'b1; step(5);
        chk("ramp_drive", drive, 2'b10);
        chk("ramp_speed0", speed, 0);
        step(7);
        chk("ramp_pre_tick", speed, 0);
        step(1);
        chk("ramp_tick1", speed, 1);
        step(47);
        chk("ramp_speed6", speed, 6);
        step(1);
        chk("ramp_speed7", speed, 7);
        step(30);
        chk("ramp_saturate", speed, 7);
        drain("drain_ramp", 10);

        // reversal: brake through zero, then reverse ramp
        for (int s = 6; s >= 0; s--) push(2'b00, 2'b10, s, 1);
        push(2'b00, 2'b00, 0, 0);
        push(2'b00, 2'b01, 0, 0);
        push(2'b00, 2'b01, 1, 0);
        key_down[KF] = 1'b0; key_down[KB] = 1'b1; step(4);
        chk("rev_pre_brake", braking, 0);
        step(1);
        chk("rev_braking", braking, 1);
        chk("rev_brake_drive", drive, 2'b10);
        chk("rev_brake_speed", speed, 7);
        step(56);
        chk("rev_speed0", speed, 0);
        chk("rev_still_brake", braking, 1);
        step(1);
        chk("rev_idle", drive, 2'b00);
        step(1);
        chk("rev_drive", drive, 2'b01);
        step(8);
        chk("rev_speed1", speed, 1);
        push(2'b00, 2'b01, 0, 1);
        push(2'b00, 2'b00, 0, 0);
        key_down[KB] = 1'b0;
        drain("drain_rev", 40);

        // brake recovery resumes from current speed
        push(2'b00, 2'b10, 0, 0);
        for (int s = 1; s <= 5; s++) push(2'b00, 2'b10, s, 0);
        push(2'b00, 2'b10, 4, 1);
        push(2'b00, 2'b10, 3, 1);
        for (int s = 4; s <= 7; s++) push(2'b00, 2'b10, s, 0);
        key_down[KF] = 1'b1; step(45);
        chk("rec_speed5", speed, 5);
        key_down[KF] = 1'b0; step(5);
        chk("rec_braking", braking, 1);
        step(16);
        chk("rec_speed3", speed, 3);
        key_down[KF] = 1'b1; step(5);
        chk("rec_resume_brk", braking, 0);
        chk("rec_resume_speed", speed, 3);
        chk("rec_resume_drive", drive, 2'b10);
        step(7);
        chk("rec_hold3", speed, 3);
        step(1);
        chk("rec_speed4", speed, 4);
        step(24);
        chk("rec_speed7", speed, 7);
        drain("drain_rec", 10);

        // reset mid-ramp at speed 4
        for (int s = 6; s >= 0; s--) push(2'b00, 2'b10, s, 1);
        push(2'b00, 2'b00, 0, 0);
        key_down[KF] = 1'b0;
        drain("drain_pre_rst", 100);
        push(2'b00, 2'b10, 0, 0);
        for (int s = 1; s <= 4; s++) push(2'b00, 2'b10, s, 0);
        key_down[KF] = 1'b1; step(38);
        chk("mid_speed4", speed, 4);
        rst_n = 1'b0; key_down = '0; step(1);
        chk("mid_rst_drive", drive, 0);
        chk("mid_rst_speed", speed, 0);
        chk("mid_rst_braking", braking, 0);
        chk("mid_rst_cmd_chg", cmd_chg, 0);
        rst_n = 1'b1; step(10);
        chk("post_rst_drive", drive, 0);
        chk("post_rst_speed", speed, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
